// File: rtl/serial_subtractor_pkg.sv
// Shared constants for the bit-serial subtractor: FSM encoding and default width.
package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_fs_bit.sv
// One-bit full subtractor: two half-subtractor stages, borrows ORed together.
module fs_bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic d1, b1, b2;

  assign d1   = a ^ b;
  assign b1   = ~a & b;
  assign d    = d1 ^ bin;
  assign b2   = ~d1 & bin;
  assign bout = b1 | b2;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A - B - Bin, LSB first, one bit per clock through a single fs_bit cell.
//
// state | meaning
// IDLE  | waiting for start, outputs hold last result
// SHIFT | one operand bit per cycle, WIDTH cycles
// DONE  | publish result, optionally accept next operands
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] D,
  output logic             Br,
  output logic             OV,
  output logic             Z
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_sh, b_sh, res;
  logic             a_msb, b_msb, brw;
  logic             cell_d, cell_bout;
  logic             load;

  fs_bit u_fs_bit (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (brw),
    .d    (cell_d),
    .bout (cell_bout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == LAST_BIT) state_nxt = DONE;
      end
      DONE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Operands shift right so the cell always sees bit 0; MSBs are kept for OV.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      a_sh  <= '0;
      b_sh  <= '0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      brw   <= 1'b0;
      res   <= '0;
    end else if (load) begin
      cnt   <= '0;
      a_sh  <= A;
      b_sh  <= B;
      a_msb <= A[WIDTH-1];
      b_msb <= B[WIDTH-1];
      brw   <= Bin;
      res   <= '0;
    end else if (state == SHIFT) begin
      cnt  <= cnt + 1'b1;
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      res  <= {cell_d, res[WIDTH-1:1]};
      brw  <= cell_bout;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      D     <= '0;
      Br    <= 1'b0;
      OV    <= 1'b0;
      Z     <= 1'b1;
    end else begin
      valid <= (state == DONE);
      if (state == DONE) begin
        D  <= res;
        Br <= brw;
        OV <= (a_msb != b_msb) && (res[WIDTH-1] != a_msb);
        Z  <= (res == '0);
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=8): vector table plus multi-cycle sequences.
module tb_serial_subtractor;

  logic       clk, rst, start, Bin;
  logic [7:0] A, B;
  logic       busy, valid, Br, OV, Z;
  logic [7:0] D;

  int n_checks = 0;
  int n_fail   = 0;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .Bin   (Bin),
    .busy  (busy),
    .valid (valid),
    .D     (D),
    .Br    (Br),
    .OV    (OV),
    .Z     (Z)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] d;
    logic       br;
    logic       ov;
    logic       z;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Starts one operation, scrambles inputs while busy, returns edges from start to valid.
  task automatic apply_op(input logic [7:0] a, input logic [7:0] b, input logic bin,
                          output int lat);
    @(negedge clk);
    A = a; B = b; Bin = bin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    A = ~a; B = 8'($urandom); Bin = ~bin;
    check("busy_after_start", busy, 1);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (valid) begin
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, nv, vedge;
    logic [7:0] ca [4];
    logic [7:0] cb [4];
    logic [7:0] cd [3];

    vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{8'h00, 8'h80, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0};
    vecs[8] = '{8'hAA, 8'h55, 1'b0, 8'h55, 1'b0, 1'b1, 1'b0};
    vecs[9] = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0};

    clk = 1'b0; rst = 1'b1; start = 1'b0; A = '0; B = '0; Bin = 1'b0;
    #12;
    check("rst_busy",  busy,  0);
    check("rst_valid", valid, 0);
    check("rst_D",     D,     0);
    check("rst_Br",    Br,    0);
    check("rst_OV",    OV,    0);
    check("rst_Z",     Z,     1);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      apply_op(vecs[i].a, vecs[i].b, vecs[i].bin, lat);
      check($sformatf("vec%0d_latency", i), lat, 9);
      check($sformatf("vec%0d_D", i),  D,  vecs[i].d);
      check($sformatf("vec%0d_Br", i), Br, vecs[i].br);
      check($sformatf("vec%0d_OV", i), OV, vecs[i].ov);
      check($sformatf("vec%0d_Z", i),  Z,  vecs[i].z);
      @(posedge clk); #1;
      check($sformatf("vec%0d_valid_pulse", i), valid, 0);
      check($sformatf("vec%0d_idle", i), busy, 0);
      check($sformatf("vec%0d_hold_D", i), D, vecs[i].d);
    end

    // start re-asserted mid-SHIFT with new operands must be ignored
    @(negedge clk);
    A = 8'h20; B = 8'h10; Bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1; A = 8'hFF; B = 8'h00;
    @(posedge clk); #1;
    start = 1'b0;
    nv = 0; vedge = 0;
    for (int e = 5; e <= 20; e++) begin
      @(posedge clk); #1;
      if (valid) begin
        nv++;
        vedge = e;
        check("ignore_D", D, 8'h10);
      end
    end
    check("ignore_valid_count", nv, 1);
    check("ignore_valid_edge", vedge, 9);

    // asynchronous reset in the 4th SHIFT cycle aborts the operation
    @(negedge clk);
    A = 8'h55; B = 8'h11; Bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy",  busy,  0);
    check("abort_valid", valid, 0);
    check("abort_D",     D,     0);
    check("abort_Z",     Z,     1);
    check("abort_Br",    Br,    0);
    @(negedge clk);
    rst = 1'b0;
    nv = 0;
    for (int e = 0; e < 12; e++) begin
      @(posedge clk); #1;
      if (valid) nv++;
    end
    check("abort_no_valid", nv, 0);
    check("abort_D_held", D, 0);
    apply_op(8'h55, 8'h11, 1'b0, lat);
    check("post_rst_latency", lat, 9);
    check("post_rst_D", D, 8'h44);
    check("post_rst_Z", Z, 0);

    // start held high: back-to-back operations, operands taken at each DONE
    ca[0] = 8'h30; cb[0] = 8'h10; cd[0] = 8'h20;
    ca[1] = 8'h01; cb[1] = 8'h02; cd[1] = 8'hFF;
    ca[2] = 8'h44; cb[2] = 8'h44; cd[2] = 8'h00;
    ca[3] = 8'h00; cb[3] = 8'h00;
    @(negedge clk);
    A = ca[0]; B = cb[0]; Bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    A = ca[1]; B = cb[1];
    for (int e = 1; e <= 27; e++) begin
      @(posedge clk); #1;
      if (e % 9 == 0) begin
        check($sformatf("b2b_valid_e%0d", e), valid, 1);
        check($sformatf("b2b_D_e%0d", e), D, cd[e/9-1]);
        check($sformatf("b2b_busy_e%0d", e), busy, 1);
        A = ca[e/9+1]; B = cb[e/9+1];
      end else begin
        check($sformatf("b2b_novalid_e%0d", e), valid, 0);
      end
    end
    start = 1'b0;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (valid) begin
        lat = k;
        break;
      end
    end
    check("b2b_tail_latency", lat, 9);
    check("b2b_tail_D", D, 8'h00);
    check("b2b_tail_Z", Z, 1);
    @(posedge clk); #1;
    check("b2b_tail_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, meaning operand/result width in bits; legal range 2..32.
REQ-002 Clocking SHALL be fixed: one clock; reset is asynchronous and active-high (ports clk, rst).
REQ-003 Port clk SHALL be input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 Port rst SHALL be input, 1 bit, the asynchronous active-high reset.
REQ-005 Port start SHALL be input, 1 bit, a request to begin a subtraction.
REQ-006 Port A SHALL be input, WIDTH bits, the minuend, sampled with start.
REQ-007 Port B SHALL be input, WIDTH bits, the subtrahend, sampled with start.
REQ-008 Port Bin SHALL be input, 1 bit, the borrow-in, sampled with start.
REQ-009 Port busy SHALL be output, 1 bit, high while an operation is in progress.
REQ-010 Port valid SHALL be output, 1 bit, a one-cycle pulse marking new results.
REQ-011 Port D SHALL be output, WIDTH bits, the difference A-B-Bin modulo 2^WIDTH.
REQ-012 Port Br SHALL be output, 1 bit, the unsigned borrow-out (A < B+Bin).
REQ-013 Port OV SHALL be output, 1 bit, the two's-complement signed overflow flag.
REQ-014 Port Z SHALL be output, 1 bit, high when D is all zeros.

Function
REQ-015 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-016 In IDLE with start=1, the block SHALL latch A, B and Bin (borrow register := Bin), clear the bit counter and go to SHIFT.
REQ-017 Each SHIFT cycle SHALL process one bit LSB-first, using the full-subtractor cell on bit i of A and B with the borrow register.
REQ-018 In each SHIFT cycle the block SHALL shift diff bit i into the result register and update the borrow register.
REQ-019 SHIFT SHALL last exactly WIDTH cycles and then go to DONE.
REQ-020 In DONE the block SHALL pulse valid for one cycle and update D, Br, OV and Z together from the completed operation.
REQ-021 D, Br, OV and Z SHALL hold their values until the next DONE or reset.
REQ-022 OV SHALL equal (A[MSB] != B[MSB]) && (D[MSB] != A[MSB]); Bin is included in the difference.
REQ-023 Latency SHALL be fixed: start sampled at edge 0 gives valid=1 in the cycle after edge WIDTH+1.
REQ-024 busy SHALL be 1 in SHIFT and DONE and 0 in IDLE.
REQ-025 start SHALL be ignored in SHIFT: operands are not re-sampled and the operation in flight is unaffected.
REQ-026 In DONE with start=1, the block SHALL latch new operands and go directly to SHIFT (back-to-back, period WIDTH+1).
REQ-027 In DONE with start=0, the block SHALL return to IDLE.
REQ-028 A change on A, B or Bin while busy SHALL have no effect on the result in flight.

Reset
REQ-029 When rst is asserted, state SHALL become IDLE immediately, regardless of clk.
REQ-030 On reset, the counter, borrow register, operand and result registers SHALL be cleared.
REQ-031 On reset, the outputs SHALL be busy=0, valid=0, D=0, Br=0, OV=0 and Z=1 (Z reflects D=0).
REQ-032 Reset asserted mid-operation SHALL abort the operation: no valid pulse and no partial result on D.
REQ-033 After rst deasserts, the first rising edge SHALL be able to accept start.

Structure
REQ-034 The state encoding constants (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) SHALL be defined in a shared package/header.
REQ-035 The default WIDTH SHALL be defined in the same shared package/header.
REQ-036 The bit counter width SHALL be $clog2(WIDTH+1).
REQ-037 A combinational sub-module fs_bit (inputs a, b, bin; outputs d, bout) SHALL implement the per-bit cell.
REQ-038 fs_bit SHALL be built from two half-subtractor stages plus an OR of their borrows.
REQ-039 fs_bit SHALL be instantiated once and reused every SHIFT cycle.

Verification (WIDTH=8)
REQ-040 A=0x05, B=0x03, Bin=0 -> valid at edge 9: D=0x02, Br=0, OV=0, Z=0.
REQ-041 A=0x03, B=0x05, Bin=0 -> D=0xFE, Br=1, OV=0, Z=0.
REQ-042 A=0x80, B=0x01, Bin=0 -> D=0x7F, Br=0, OV=1; then A=0x10, B=0x0F, Bin=1 -> D=0x00, Z=1, Br=0.
REQ-043 start at edge 0 (A=0x20, B=0x10), then start pulsed at edge 4 with A=0xFF, B=0x00 -> single valid at edge 9 with D=0x10.
REQ-044 start held high continuously -> valid every 9 cycles with the operands present at each DONE.
REQ-045 rst asserted asynchronously at cycle 4 of SHIFT -> busy=0 immediately, no valid, D=0x00, Z=1; the next start computes correctly.
